tx_eq_coeff_ctrl: RTL and testbench
===================================

# tx_eq_coeff_ctrl

Configuration and sequencing controller for the TX feed-forward/feedback equalizer. It accepts coefficient writes for K1..K4 into shadow registers over a valid/ready port. On request, it commits all four coefficients atomically at the next frame boundary, then asserts a flush window so the equalizer clears its input/output history before new-coefficient output is used. It sits between the link configuration bus and the equalizer datapath, and owns the TX frame counter.

## Interface
Parameters:
- COEF_W, 16, width of each coefficient (unsigned, same fixed-point format as the equalizer)
- FRAME_LEN, 64, symbols per frame; ≥ 2
- FLUSH_CYCLES, 3, cycles eq_flush is held after a commit; ≥ 1
- RST_K1 / RST_K2 / RST_K3 / RST_K4, 1 / 0 / 0 / 0, active and shadow coefficient values after reset (pass-through)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- cfg_valid  in  1  write request
- cfg_ready  out  1  write accepted when cfg_valid && cfg_ready
- cfg_addr  in  2  0=K1, 1=K2, 2=K3, 3=K4
- cfg_data  in  COEF_W  coefficient value
- cfg_commit  in  1  single-cycle request to apply shadow set
- commit_done  out  1  one-cycle pulse: commit and flush complete
- commit_err  out  1  one-cycle pulse: cfg_commit received while not IDLE
- k1, k2, k3, k4  out  COEF_W each  active coefficients to equalizer
- eq_flush  out  1  equalizer history clear/hold
- frame_sof  out  1  high when frame counter == 0
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, WAIT_BND, FLUSH.
- IDLE: cfg_ready=1. Accepted write updates shadow[cfg_addr] <= cfg_data. cfg_commit -> WAIT_BND.
- Write and commit in the same IDLE cycle: the write lands in shadow first, and the commit includes it.
- WAIT_BND: cfg_ready=0, so writes are not accepted. When frame count == FRAME_LEN-1: k1..k4 <= shadow (all four on one edge), flush_cnt <= FLUSH_CYCLES-1, go to FLUSH.
- FLUSH: cfg_ready=0, eq_flush=1. Decrement flush_cnt each cycle. At flush_cnt==0 -> IDLE, commit_done pulses on the next cycle.
- cfg_commit in WAIT_BND or FLUSH: ignored, commit_err pulses the next cycle, and the in-flight commit is unaffected.
- Frame counter: free-running 0..FRAME_LEN-1, wraps to 0, never stalls. It is not affected by the FSM.
- Shadow registers persist across commits. Recommitting with no intervening writes reapplies the same values.
- Reset (rst=0) at any point, including mid-WAIT_BND or mid-FLUSH, takes effect on that edge:
  - state=IDLE
  - shadow and k* = RST_K*
  - frame counter=0
  - eq_flush=0, commit_done=0, commit_err=0
  - the pending commit is dropped
- Reset values of all outputs:
  - cfg_ready=1, k*=RST_K*, eq_flush=0, frame_sof=1, busy=0
  - commit_done=0, commit_err=0

## Timing
- All outputs are registered or decoded directly from registered state, with no combinational path from inputs to outputs.
- Exception: cfg_ready is a decode of state only.
- cfg_commit sampled in cycle t (IDLE) -> busy=1 from t+1.
- Boundary cycle n is the first cycle ≥ t+1 with count == FRAME_LEN-1. If the count equals FRAME_LEN-1 at t+1, n = t+1.
- New k* are visible from n+1, coincident with frame_sof=1.
- eq_flush is high for cycles n+1..n+FLUSH_CYCLES.
- busy=0 and commit_done=1 at n+FLUSH_CYCLES+1.
- Commit latency ranges from FLUSH_CYCLES+2 to FRAME_LEN+FLUSH_CYCLES+1 cycles.

## Structure
- Package tx_eq_pkg holds:
  - state enum {IDLE, WAIT_BND, FLUSH}
  - address constants ADDR_K1..ADDR_K4
  - default COEF_W
- Sub-module tx_eq_frame_cnt (parameter FRAME_LEN; outputs count, sof, eof) holds the free-running counter.
- The FSM, shadow/active registers and flush counter live in the top.

## Test plan
FRAME_LEN=8, FLUSH_CYCLES=3, COEF_W=16.
- Reset release -> k1=1, k2=k3=k4=0, cfg_ready=1, frame_sof=1, and frame_sof recurs every 8 cycles.
- Write K1=0x0120, K2=0x0020, K3=0x0008, K4=0x0002, then commit with count=2 -> k* unchanged until count wraps. All four change on the same edge as frame_sof. eq_flush is high for exactly 3 cycles, then commit_done pulses once.
- Commit issued when count=6, so WAIT_BND starts at count=7 -> apply at that boundary. Total latency from commit to commit_done is 5 cycles.
- cfg_valid held with K2=0x0055 during WAIT_BND -> cfg_ready=0, no accept. It is accepted only after returning to IDLE and does not alter the active k2.
- Second cfg_commit during FLUSH -> commit_err pulses once, with a single commit_done and no second flush.
- rst=0 asserted mid-FLUSH -> next cycle: eq_flush=0, k*=RST_K*, busy=0, count=0, and no commit_done.

Source files
------------

// File: rtl/tx_eq_pkg.sv
// Shared types and constants for the TX equalizer coefficient controller.
package tx_eq_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_BND = 2'd1,
        FLUSH    = 2'd2
    } state_e;

    localparam logic [1:0] ADDR_K1 = 2'd0;
    localparam logic [1:0] ADDR_K2 = 2'd1;
    localparam logic [1:0] ADDR_K3 = 2'd2;
    localparam logic [1:0] ADDR_K4 = 2'd3;

    localparam int NUM_COEF   = 4;
    localparam int DEF_COEF_W = 16;

endpackage

// File: rtl/tx_eq_frame_cnt.sv
// Free-running TX frame counter: 0..FRAME_LEN-1, wraps, never stalls.
module tx_eq_frame_cnt
    import tx_eq_pkg::*;
#(
    parameter int FRAME_LEN = 64,
    localparam int CNT_W    = $clog2(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] count_o,
    output logic             sof_o,
    output logic             eof_o
);

    logic [CNT_W-1:0] count_q, count_d;

    assign eof_o = (count_q == CNT_W'(FRAME_LEN - 1));
    assign sof_o = (count_q == '0);

    always_comb begin
        count_d = count_q + 1'b1;
        if (eof_o) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/tx_eq_coeff_ctrl.sv
// Shadow/active coefficient registers for the TX equalizer with atomic
// frame-boundary commit followed by a history flush window.
module tx_eq_coeff_ctrl
    import tx_eq_pkg::*;
#(
    parameter int                COEF_W       = DEF_COEF_W,
    parameter int                FRAME_LEN    = 64,
    parameter int                FLUSH_CYCLES = 3,
    parameter logic [COEF_W-1:0] RST_K1       = COEF_W'(1),
    parameter logic [COEF_W-1:0] RST_K2       = COEF_W'(0),
    parameter logic [COEF_W-1:0] RST_K3       = COEF_W'(0),
    parameter logic [COEF_W-1:0] RST_K4       = COEF_W'(0)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [1:0]        cfg_addr,
    input  logic [COEF_W-1:0] cfg_data,
    input  logic              cfg_commit,
    output logic              commit_done,
    output logic              commit_err,
    output logic [COEF_W-1:0] k1,
    output logic [COEF_W-1:0] k2,
    output logic [COEF_W-1:0] k3,
    output logic [COEF_W-1:0] k4,
    output logic              eq_flush,
    output logic              frame_sof,
    output logic              busy
);

    localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int CNT_W = $clog2(FRAME_LEN);

    state_e            state_q, state_d;
    logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              apply;
    logic              wr_en;
    logic [NUM_COEF-1:0] wr_sel;
    logic [COEF_W-1:0] shadow_q [NUM_COEF];
    logic [COEF_W-1:0] k_q      [NUM_COEF];

    logic [CNT_W-1:0]  frame_count;
    logic              frame_start;
    logic              frame_end;
    logic              unused_frame_count;

    function automatic logic [COEF_W-1:0] rst_coef(input int idx);
        case (idx)
            0:       return RST_K1;
            1:       return RST_K2;
            2:       return RST_K3;
            default: return RST_K4;
        endcase
    endfunction

    tx_eq_frame_cnt #(
        .FRAME_LEN (FRAME_LEN)
    ) u_frame_cnt (
        .clk     (clk),
        .rst     (rst),
        .count_o (frame_count),
        .sof_o   (frame_start),
        .eof_o   (frame_end)
    );

    // Boundary detection uses the decoded flags; the raw count is not needed here.
    assign unused_frame_count = ^frame_count;

    // Writes only land while idle, so the shadow set is frozen during a commit.
    assign wr_en = cfg_valid && (state_q == IDLE);

    for (genvar gi = 0; gi < NUM_COEF; gi++) begin : g_wr_sel
        assign wr_sel[gi] = wr_en && (cfg_addr == 2'(gi));
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        apply       = 1'b0;
        done_d      = 1'b0;
        err_d       = cfg_commit && (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (cfg_commit) begin
                    state_d = WAIT_BND;
                end
            end
            WAIT_BND: begin
                if (frame_end) begin
                    apply       = 1'b1;
                    flush_cnt_d = FC_W'(FLUSH_CYCLES - 1);
                    state_d     = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            flush_cnt_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // All four active coefficients move on the same edge as the wrap to count 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_COEF; i++) begin
                shadow_q[i] <= rst_coef(i);
                k_q[i]      <= rst_coef(i);
            end
        end else begin
            for (int i = 0; i < NUM_COEF; i++) begin
                if (wr_sel[i]) begin
                    shadow_q[i] <= cfg_data;
                end
                if (apply) begin
                    k_q[i] <= shadow_q[i];
                end
            end
        end
    end

    assign cfg_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign eq_flush    = (state_q == FLUSH);
    assign commit_done = done_q;
    assign commit_err  = err_q;
    assign frame_sof   = frame_start;
    assign k1          = k_q[ADDR_K1];
    assign k2          = k_q[ADDR_K2];
    assign k3          = k_q[ADDR_K3];
    assign k4          = k_q[ADDR_K4];

endmodule

// File: tb/tb_tx_eq_coeff_ctrl.sv
// Randomized bench for tx_eq_coeff_ctrl with a timeline-based reference model
// and a scoreboard of expected commit_done / commit_err pulses.
module tb_tx_eq_coeff_ctrl;

    localparam int FL = 8;
    localparam int FC = 3;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_addr;
    logic [CW-1:0] cfg_data;
    logic          cfg_commit;
    logic          commit_done;
    logic          commit_err;
    logic [CW-1:0] k1, k2, k3, k4;
    logic          eq_flush;
    logic          frame_sof;
    logic          busy;

    tx_eq_coeff_ctrl #(
        .COEF_W       (CW),
        .FRAME_LEN    (FL),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .cfg_commit  (cfg_commit),
        .commit_done (commit_done),
        .commit_err  (commit_err),
        .k1          (k1),
        .k2          (k2),
        .k3          (k3),
        .k4          (k4),
        .eq_flush    (eq_flush),
        .frame_sof   (frame_sof),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    typedef struct {
        int                   at;
        logic [3:0][CW-1:0]   kv;
    } done_t;

    done_t done_q[$];
    int    err_q[$];

    // Reference model: commits are described by the cycles at which things happen.
    logic [3:0][CW-1:0] rst_set = {16'd0, 16'd0, 16'd0, 16'd1};
    logic [3:0][CW-1:0] sh;
    logic [3:0][CW-1:0] k_old;
    logic [3:0][CW-1:0] k_new;
    int r_cyc = 0;
    bit pend  = 1'b0;
    int tc    = 0;
    int a_cyc = 0;
    int d_cyc = 0;
    bit last_acc = 1'b0;

    function automatic int m_count(input int k);
        return (k - r_cyc) % FL;
    endfunction

    function automatic bit m_busy(input int k);
        return pend && (k >= tc + 1) && (k < d_cyc);
    endfunction

    function automatic bit m_flush(input int k);
        return pend && (k >= a_cyc) && (k < d_cyc);
    endfunction

    function automatic logic [3:0][CW-1:0] m_k(input int k);
        return (pend && k >= a_cyc) ? k_new : k_old;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // Stimulus for cycle t = cyc is applied here and fed to the model.
    task automatic issue(input bit v, input logic [1:0] a, input logic [CW-1:0] d,
                         input bit c, input bit rn);
        int t;
        int n;
        bit idle;
        t = cyc;
        last_acc = 1'b0;
        if (!rn) begin
            r_cyc = t + 1;
            pend  = 1'b0;
            k_old = rst_set;
            sh    = rst_set;
            done_q.delete();
            err_q.delete();
        end else begin
            idle = !m_busy(t);
            if (v && idle) begin
                sh[a]    = d;
                last_acc = 1'b1;
            end
            if (c) begin
                if (idle) begin
                    if (pend) k_old = k_new;
                    n = t + 1;
                    while (m_count(n) != FL - 1) n++;
                    tc    = t;
                    a_cyc = n + 1;
                    d_cyc = n + FC + 1;
                    k_new = sh;
                    pend  = 1'b1;
                    done_q.push_back('{d_cyc, k_new});
                end else begin
                    err_q.push_back(t + 1);
                end
            end
        end
    endtask

    task automatic step(input bit v, input logic [1:0] a, input logic [CW-1:0] d,
                        input bit c, input bit rn);
        @(negedge clk);
        cfg_valid  = v;
        cfg_addr   = a;
        cfg_data   = d;
        cfg_commit = c;
        rst        = rn;
        issue(v, a, d, c, rn);
    endtask

    task automatic idle_step();
        step(1'b0, 2'd0, '0, 1'b0, 1'b1);
    endtask

    task automatic idle_until_count(input int c);
        for (int i = 0; i < 4 * FL && m_count(cyc + 1) != c; i++) idle_step();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 4 * FL && m_busy(cyc + 1); i++) idle_step();
    endtask

    // Monitor: per-cycle state checks plus scoreboard pops on pulses.
    always begin
        @(posedge clk);
        #1;
        if (chk_en) begin
            int k;
            logic [3:0][CW-1:0] ek;
            done_t e;
            int ec;
            k  = cyc;
            ek = m_k(k);
            chk("busy",      32'(busy),      32'(m_busy(k)));
            chk("cfg_ready", 32'(cfg_ready), 32'(!m_busy(k)));
            chk("eq_flush",  32'(eq_flush),  32'(m_flush(k)));
            chk("frame_sof", 32'(frame_sof), 32'(m_count(k) == 0));
            chk("k1", 32'(k1), 32'(ek[0]));
            chk("k2", 32'(k2), 32'(ek[1]));
            chk("k3", 32'(k3), 32'(ek[2]));
            chk("k4", 32'(k4), 32'(ek[3]));

            if (commit_done === 1'b1) begin
                if (done_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done cyc=%0d got=1 want=0", k);
                end else begin
                    e = done_q.pop_front();
                    chk("done_cycle", 32'(k), 32'(e.at));
                    chk("done_k", 32'({k4, k3, k2, k1} == e.kv), 32'd1);
                    $display("commit_done cyc=%0d k1=%h k2=%h k3=%h k4=%h", k, k1, k2, k3, k4);
                end
            end else if (done_q.size() > 0 && done_q[0].at <= k) begin
                total++; bad++;
                $display("FAIL missing_done cyc=%0d got=0 want=1", k);
                void'(done_q.pop_front());
            end

            if (commit_err === 1'b1) begin
                if (err_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_err cyc=%0d got=1 want=0", k);
                end else begin
                    ec = err_q.pop_front();
                    chk("err_cycle", 32'(k), 32'(ec));
                    $display("commit_err cyc=%0d", k);
                end
            end else if (err_q.size() > 0 && err_q[0] <= k) begin
                total++; bad++;
                $display("FAIL missing_err cyc=%0d got=0 want=1", k);
                void'(err_q.pop_front());
            end
        end
    end

    initial begin
        logic [CW-1:0] tv [4];
        tv[0] = 16'h0120; tv[1] = 16'h0020; tv[2] = 16'h0008; tv[3] = 16'h0002;
        rst = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0;

        step(1'b0, 2'd0, '0, 1'b0, 1'b0);
        chk_en = 1'b1;
        step(1'b0, 2'd0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) idle_step();

        // Four writes, then commit with count=2.
        for (int i = 0; i < 4; i++) step(1'b1, 2'(i), tv[i], 1'b0, 1'b1);
        idle_until_count(2);
        step(1'b0, 2'd0, '0, 1'b1, 1'b1);
        $display("commit issued cyc=%0d count=2", cyc);
        wait_idle();

        // Commit at count=6: shortest latency.
        idle_until_count(6);
        step(1'b0, 2'd0, '0, 1'b1, 1'b1);
        $display("commit issued cyc=%0d count=6", cyc);
        wait_idle();
        idle_step();

        // Hold a K2 write across a whole commit; it lands only once idle.
        idle_until_count(1);
        step(1'b0, 2'd0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 4 * FL; i++) begin
            step(1'b1, 2'd1, 16'h0055, 1'b0, 1'b1);
            if (last_acc) break;
        end
        $display("held write accepted=%0d cyc=%0d", last_acc, cyc);
        idle_step();
        idle_step();
        step(1'b0, 2'd0, '0, 1'b1, 1'b1);
        wait_idle();

        // Second commit during FLUSH.
        step(1'b0, 2'd0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 4 * FL && cyc + 1 < a_cyc; i++) idle_step();
        step(1'b0, 2'd0, '0, 1'b1, 1'b1);
        wait_idle();
        idle_step();

        // Reset in the middle of FLUSH.
        step(1'b1, 2'd2, 16'h0777, 1'b1, 1'b1);
        for (int i = 0; i < 4 * FL && cyc + 1 < a_cyc + 1; i++) idle_step();
        step(1'b0, 2'd0, '0, 1'b0, 1'b0);
        $display("reset asserted mid-flush cyc=%0d", cyc);
        idle_step();
        idle_step();

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 59) != 0));
        end

        for (int i = 0; i < 30; i++) idle_step();
        @(posedge clk);
        #2;
        chk("drain", 32'(done_q.size() + err_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
